// File: rtl/spi_hid_pkg.sv
// spi_hid_pkg -- shared definitions for the SPI HID frame receiver.
//   * command codes sent by the ARM in byte 0 of a frame
//   * payload length (in bytes) per command
//   * receiver FSM state encoding
//   * joystick bit positions inside a JOYx word
package spi_hid_pkg;

    localparam logic [7:0] CMD_JOY0  = 8'h01;
    localparam logic [7:0] CMD_JOY1  = 8'h02;
    localparam logic [7:0] CMD_MOUSE = 8'h04;

    localparam logic [1:0] LEN_JOY   = 2'd1;
    localparam logic [1:0] LEN_MOUSE = 2'd3;

    // JOYx word is {fire2,fire,up,down,left,right}
    localparam int JOY_RIGHT = 0;
    localparam int JOY_FIRE2 = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_SKIP    = 2'd3
    } state_t;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_JOY0) || (cmd == CMD_JOY1) || (cmd == CMD_MOUSE);
    endfunction

    function automatic logic [1:0] payload_len(input logic [7:0] cmd);
        return (cmd == CMD_MOUSE) ? LEN_MOUSE : LEN_JOY;
    endfunction

endpackage

// File: rtl/spi_hid_sync.sv
// spi_hid_sync -- brings the asynchronous SPI pins into the CPU clock domain.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   spi_ck/nss/mosi       raw SPI pins
//   sck_rise, sck_fall    one-cycle pulses on synchronised SCK edges
//   nss_fall              one-cycle pulse when synchronised NSS goes low
//   nss_high              synchronised NSS level (1 = deselected)
//   mosi                  synchronised MOSI, aligned with sck_rise
// All sync flops reset to 0, so NSS must be seen high before a falling edge
// can be reported; a reset released mid-frame never starts a bogus frame.
module spi_hid_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_ck,
    input  logic spi_nss,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic nss_fall,
    output logic nss_high,
    output logic mosi
);

    logic [2:0] raw;
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic       sck_prev_q;
    logic       nss_prev_q;

    // bit 0 = SCK, bit 1 = NSS, bit 2 = MOSI
    assign raw = {spi_mosi, spi_nss, spi_ck};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_q[gi] <= 1'b0;
                    sync_q[gi] <= 1'b0;
                end else begin
                    meta_q[gi] <= raw[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q <= 1'b0;
            nss_prev_q <= 1'b0;
        end else begin
            sck_prev_q <= sync_q[0];
            nss_prev_q <= sync_q[1];
        end
    end

    assign sck_rise = sync_q[0] & ~sck_prev_q;
    assign sck_fall = ~sync_q[0] & sck_prev_q;
    assign nss_fall = ~sync_q[1] & nss_prev_q;
    assign nss_high = sync_q[1];
    assign mosi     = sync_q[2];

endmodule

// File: rtl/spi_hid_rx.sv
// spi_hid_rx -- SPI-slave receiver for HID frames (joystick / mouse) from the ARM.
// Ports:
//   CLKCPU_A, RESET_n     system clock, asynchronous active-low reset
//   SPI_CK/NSS/MOSI       SPI mode-0 slave inputs (oversampled)
//   SPI_MISO              CORE_ID during byte 0 of a frame, 0 otherwise
//   JOY0, JOY1            {fire2,fire,up,down,left,right}, 1 = pressed
//   MOUSE_BUTTONS         {middle,right,left}
//   MOUSE_DATA            {ycount,xcount}, accumulated 8-bit counters
//   FRAME_STB             one-cycle pulse when a frame is committed
// Optional: define SPI_HID_WATCHDOG_EN to release JOY0/JOY1/MOUSE_BUTTONS
// after TIMEOUT_CYCLES cycles without a committed frame.
module spi_hid_rx
    import spi_hid_pkg::*;
#(
    parameter logic [7:0]  CORE_ID        = 8'hA1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic        CLKCPU_A,
    input  logic        RESET_n,
    input  logic        SPI_CK,
    input  logic        SPI_NSS,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    output logic [5:0]  JOY0,
    output logic [5:0]  JOY1,
    output logic [2:0]  MOUSE_BUTTONS,
    output logic [15:0] MOUSE_DATA,
    output logic        FRAME_STB
);

    logic sck_rise, sck_fall, nss_fall, nss_high, mosi;

    spi_hid_sync u_sync (
        .clk      (CLKCPU_A),
        .rst_n    (RESET_n),
        .spi_ck   (SPI_CK),
        .spi_nss  (SPI_NSS),
        .spi_mosi (SPI_MOSI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .nss_fall (nss_fall),
        .nss_high (nss_high),
        .mosi     (mosi)
    );

    state_t      state_q, state_d;
    logic [6:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [2:0]  btn_hold_q, btn_hold_d;
    logic [7:0]  dx_hold_q, dx_hold_d;
    logic [7:0]  miso_sr_q, miso_sr_d;
    logic [5:0]  joy0_q, joy0_d, joy1_q, joy1_d;
    logic [2:0]  buttons_q, buttons_d;
    logic [7:0]  mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
    logic        frame_stb_q, frame_stb_d;

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        commit;

    // rx_byte is the byte as it stands once the current MOSI bit is shifted in
    assign rx_byte   = {shift_q, mosi};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

`ifdef SPI_HID_WATCHDOG_EN
    logic [23:0] wd_cnt_q, wd_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        cmd_d       = cmd_q;
        btn_hold_d  = btn_hold_q;
        dx_hold_d   = dx_hold_q;
        miso_sr_d   = miso_sr_q;
        joy0_d      = joy0_q;
        joy1_d      = joy1_q;
        buttons_d   = buttons_q;
        mouse_x_d   = mouse_x_q;
        mouse_y_d   = mouse_y_q;
        frame_stb_d = 1'b0;
        commit      = 1'b0;

        if (sck_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        // zeros shift in behind CORE_ID, so MISO reads 0 after byte 0
        if (sck_fall) begin
            miso_sr_d = {miso_sr_q[6:0], 1'b0};
        end

        case (state_q)
            ST_IDLE: begin
                shift_d    = '0;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                miso_sr_d  = '0;
                if (nss_fall) begin
                    state_d   = ST_CMD;
                    miso_sr_d = CORE_ID;
                end
            end
            ST_CMD: begin
                if (byte_done) begin
                    if (cmd_known(rx_byte)) begin
                        cmd_d      = rx_byte;
                        byte_cnt_d = '0;
                        state_d    = ST_PAYLOAD;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_done) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == payload_len(cmd_q) - 2'd1) begin
                        commit  = 1'b1;
                        state_d = ST_SKIP;
                    end else if (byte_cnt_q == 2'd0) begin
                        btn_hold_d = rx_byte[2:0];
                    end else begin
                        dx_hold_d = rx_byte;
                    end
                end
            end
            default: ; // ST_SKIP: wait for NSS to rise
        endcase

        // Deselect overrides everything, including a byte completing in the
        // same sample: the partial frame is dropped without a commit.
        if (nss_high) begin
            state_d    = ST_IDLE;
            shift_d    = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            miso_sr_d  = '0;
            commit     = 1'b0;
        end

`ifdef SPI_HID_WATCHDOG_EN
        // Saturated counter keeps the pad outputs released until a frame lands.
        if (wd_cnt_q == TIMEOUT_CYCLES - 24'd1) begin
            joy0_d    = '0;
            joy1_d    = '0;
            buttons_d = '0;
        end
`endif

        if (commit) begin
            frame_stb_d = 1'b1;
            case (cmd_q)
                CMD_JOY0: joy0_d = rx_byte[JOY_FIRE2:JOY_RIGHT];
                CMD_JOY1: joy1_d = rx_byte[JOY_FIRE2:JOY_RIGHT];
                default: begin
                    // 8-bit modulo add equals the sign-extended delta add
                    buttons_d = btn_hold_q;
                    mouse_x_d = mouse_x_q + dx_hold_q;
                    mouse_y_d = mouse_y_q + rx_byte;
                end
            endcase
        end

`ifdef SPI_HID_WATCHDOG_EN
        if (frame_stb_d) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != TIMEOUT_CYCLES - 24'd1) begin
            wd_cnt_d = wd_cnt_q + 24'd1;
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
`endif
    end

    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            cmd_q       <= '0;
            btn_hold_q  <= '0;
            dx_hold_q   <= '0;
            miso_sr_q   <= '0;
            joy0_q      <= '0;
            joy1_q      <= '0;
            buttons_q   <= '0;
            mouse_x_q   <= '0;
            mouse_y_q   <= '0;
            frame_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_q       <= cmd_d;
            btn_hold_q  <= btn_hold_d;
            dx_hold_q   <= dx_hold_d;
            miso_sr_q   <= miso_sr_d;
            joy0_q      <= joy0_d;
            joy1_q      <= joy1_d;
            buttons_q   <= buttons_d;
            mouse_x_q   <= mouse_x_d;
            mouse_y_q   <= mouse_y_d;
            frame_stb_q <= frame_stb_d;
        end
    end

`ifdef SPI_HID_WATCHDOG_EN
    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign SPI_MISO      = miso_sr_q[7];
    assign JOY0          = joy0_q;
    assign JOY1          = joy1_q;
    assign MOUSE_BUTTONS = buttons_q;
    assign MOUSE_DATA    = {mouse_y_q, mouse_x_q};
    assign FRAME_STB     = frame_stb_q;

endmodule

// File: tb/tb_spi_hid_rx.sv
// tb_spi_hid_rx -- directed frames into spi_hid_rx. Each committed frame pushes
// its expected output words into a queue; a monitor pops and compares on
// every FRAME_STB. Level checks (reset, abort, MISO, watchdog) are direct.
module tb_spi_hid_rx;

    localparam int          HALF = 8;           // SCK half period in clk cycles
    localparam logic [23:0] WD   = 24'd4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        nss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [5:0]  joy0, joy1;
    logic [2:0]  btn;
    logic [15:0] mdata;
    logic        stb;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  j0;
        logic [5:0]  j1;
        logic [2:0]  b;
        logic [15:0] m;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    spi_hid_rx #(
        .CORE_ID        (8'hA1),
        .TIMEOUT_CYCLES (WD)
    ) dut (
        .CLKCPU_A      (clk),
        .RESET_n       (rst_n),
        .SPI_CK        (sck),
        .SPI_NSS       (nss),
        .SPI_MOSI      (mosi),
        .SPI_MISO      (miso),
        .JOY0          (joy0),
        .JOY1          (joy1),
        .MOUSE_BUTTONS (btn),
        .MOUSE_DATA    (mdata),
        .FRAME_STB     (stb)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [5:0] j0, input logic [5:0] j1,
                        input logic [2:0] b, input logic [15:0] m);
        exp_t e;
        e.j0 = j0; e.j1 = j1; e.b = b; e.m = m;
        exp_q.push_back(e);
    endtask

    // Shift nbits of b MSB first; MISO is read just before each rising edge.
    task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            tick(HALF);
            rd[7-i] = miso;
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        nss = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        nss = 1'b1;
        tick(2 * HALF);
    endtask

    // Full frame of nb bytes; MISO must read A1 in byte 0 and 0 afterwards.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int nb);
        logic [7:0] bytes [4];
        logic [7:0] rd;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        frame_begin();
        for (int k = 0; k < nb; k++) begin
            spi_byte(bytes[k], 8, rd);
            if (k == 0) chk("miso_byte0", {8'h00, rd}, 16'h00A1);
            else        chk("miso_trail", {8'h00, rd}, 16'h0000);
        end
        frame_end();
        $display("frame %02h %02h %02h %02h (%0d bytes): JOY0=%h JOY1=%h BTN=%h MDATA=%h",
                 b0, b1, b2, b3, nb, joy0, joy1, btn, mdata);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && stb) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_stb", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("stb_joy0",  {10'd0, joy0}, {10'd0, e.j0});
                chk("stb_joy1",  {10'd0, joy1}, {10'd0, e.j1});
                chk("stb_btn",   {13'd0, btn},  {13'd0, e.b});
                chk("stb_mdata", mdata, e.m);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;

        // Power-on reset
        tick(4);
        chk("rst_joy0",  {10'd0, joy0}, 16'h0);
        chk("rst_joy1",  {10'd0, joy1}, 16'h0);
        chk("rst_btn",   {13'd0, btn},  16'h0);
        chk("rst_mdata", mdata, 16'h0);
        chk("rst_stb",   {15'd0, stb},  16'h0);
        chk("rst_miso",  {15'd0, miso}, 16'h0);
        rst_n = 1'b1;
        tick(4);

        push(6'h00, 6'h15, 3'b000, 16'h0000);
        send_frame(8'h02, 8'h15, 8'h00, 8'h00, 2);

        // Reset asserted mid-frame (01 + 4 bits)
        frame_begin();
        spi_byte(8'h01, 8, rd);
        spi_byte(8'h2A, 4, rd);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_joy1",  {10'd0, joy1}, 16'h0);
        chk("midrst_mdata", mdata, 16'h0);
        chk("midrst_miso",  {15'd0, miso}, 16'h0);
        rst_n = 1'b1;
        tick(2);
        sck = 1'b0;
        nss = 1'b1;
        tick(2 * HALF);

        push(6'h2A, 6'h00, 3'b000, 16'h0000);
        send_frame(8'h01, 8'h2A, 8'h00, 8'h00, 2);

        // Mouse accumulate
        push(6'h2A, 6'h00, 3'b001, 16'hFB05);
        send_frame(8'h04, 8'h01, 8'h05, 8'hFB, 4);
        push(6'h2A, 6'h00, 3'b000, 16'h0301);
        send_frame(8'h04, 8'h00, 8'hFC, 8'h08, 4);

        // Wrap: x -> FF, then FF + 01 = 00
        push(6'h2A, 6'h00, 3'b000, 16'h03FF);
        send_frame(8'h04, 8'h00, 8'hFE, 8'h00, 4);
        push(6'h2A, 6'h00, 3'b000, 16'h0300);
        send_frame(8'h04, 8'h00, 8'h01, 8'h00, 4);

        // y -> 00 with buttons, then 00 + FF = FF
        push(6'h2A, 6'h00, 3'b110, 16'h0000);
        send_frame(8'h04, 8'h06, 8'h00, 8'hFD, 4);
        push(6'h2A, 6'h00, 3'b000, 16'hFF00);
        send_frame(8'h04, 8'h00, 8'h00, 8'hFF, 4);

        // Abort: 01 + 4 bits then NSS high
        frame_begin();
        spi_byte(8'h01, 8, rd);
        spi_byte(8'h15, 4, rd);
        sck = 1'b0;
        frame_end();
        chk("abort_joy0",  {10'd0, joy0}, 16'h002A);
        chk("abort_mdata", mdata, 16'hFF00);

        // Unknown command
        send_frame(8'h7F, 8'h11, 8'h22, 8'h00, 3);
        chk("unk_joy0",  {10'd0, joy0}, 16'h002A);
        chk("unk_joy1",  {10'd0, joy1}, 16'h0000);
        chk("unk_mdata", mdata, 16'hFF00);

        // Trailing bytes ignored
        push(6'h2A, 6'h3F, 3'b000, 16'hFF00);
        send_frame(8'h02, 8'h3F, 8'h55, 8'h66, 4);
        chk("trail_joy1", {10'd0, joy1}, 16'h003F);
        chk("idle_miso",  {15'd0, miso}, 16'h0);

        // Watchdog
        push(6'h2A, 6'h10, 3'b000, 16'hFF00);
        send_frame(8'h02, 8'h10, 8'h00, 8'h00, 2);
        tick(int'(WD) + 20);
`ifdef SPI_HID_WATCHDOG_EN
        chk("wd_joy1",  {10'd0, joy1}, 16'h0000);
        chk("wd_joy0",  {10'd0, joy0}, 16'h0000);
        chk("wd_btn",   {13'd0, btn},  16'h0000);
`else
        chk("wd_joy1",  {10'd0, joy1}, 16'h0010);
        chk("wd_joy0",  {10'd0, joy0}, 16'h002A);
`endif
        chk("wd_mdata", mdata, 16'hFF00);

        tick(10);
        chk("exp_q_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_hid_rx.md
Name: spi_hid_rx

Overview:
- SPI-slave HID frame receiver. The ARM sends decoded USB joystick and mouse reports to it over the SPI link.
- It produces the registered joystick, mouse-button and accumulated mouse-counter words. The CD32 chipset-shadow logic returns these on JOYxDAT reads.
- SPI pins are oversampled in the CPU clock domain, so there is no second clock.

Parameters:
- CORE_ID, 8'hA1, byte shifted out on SPI_MISO during the first byte of every frame.
- TIMEOUT_CYCLES, 24'd2_000_000, watchdog period in CLKCPU_A cycles (used only when the optional feature is compiled in).

Ports:
- CLKCPU_A  input  1  system clock; all state on its rising edge.
- RESET_n  input  1  asynchronous active-low reset.
- SPI_CK  input  1  SPI clock (mode 0), asynchronous, max CLKCPU_A/8.
- SPI_NSS  input  1  SPI select, active-low, asynchronous.
- SPI_MOSI  input  1  SPI data in, MSB first.
- SPI_MISO  output  1  SPI data out.
- JOY0  output  6  port-0 pad {fire2,fire,up,down,left,right}, 1 = pressed.
- JOY1  output  6  port-1 pad, same format.
- MOUSE_BUTTONS  output  3  {middle,right,left}, 1 = pressed.
- MOUSE_DATA  output  16  {ycount[7:0], xcount[7:0]}, JOY0DAT format.
- FRAME_STB  output  1  one-cycle pulse when a complete valid frame is committed.

Behaviour:
- Interface: one clock, CLKCPU_A. Reset RESET_n is asynchronous, active-low.
- Reset values: JOY0, JOY1, MOUSE_BUTTONS, MOUSE_DATA, FRAME_STB and SPI_MISO are all 0. The shift register, bit counter and byte counter are cleared, and the FSM is IDLE.
- Input capture: SPI_CK, SPI_NSS and SPI_MOSI each pass through a 2-FF synchroniser.
  - Rising and falling SCK edges are detected from the synchronised SCK and its previous sample.
  - MOSI is sampled on the detected rising edge.
- Framing: byte 0 is the command; payload bytes follow.
  - 8'h01 JOY0: 1 payload byte, bits[5:0] used.
  - 8'h02 JOY1: 1 payload byte, bits[5:0] used.
  - 8'h04 MOUSE: 3 payload bytes: buttons[2:0], dx (signed 8-bit), dy (signed 8-bit).
- FSM states: IDLE, CMD, PAYLOAD, SKIP.
  - IDLE -> CMD on synchronised NSS falling.
  - CMD -> PAYLOAD on a complete byte with a known command.
  - CMD -> SKIP on a complete byte with an unknown command.
  - PAYLOAD -> SKIP after the last payload byte, with commit. Bytes beyond the payload are ignored.
  - Any state -> IDLE on synchronised NSS high.
- Commit: payload bytes are staged in holding registers. Outputs update in the cycle after the final bit is shifted in, and FRAME_STB pulses in that same cycle.
- Mouse arithmetic on commit: xcount <= xcount + dx and ycount <= ycount + dy. Both are 8-bit modulo with sign extension of the delta. Wrap-around is required (8'hFF + 8'h01 = 8'h00; 8'h00 + 8'hFF = 8'hFF).
- Abort: if NSS deasserts mid-frame, the partial payload is discarded and no output changes.
- Simultaneous events:
  - If an 8th-bit SCK edge and NSS high appear in the same synchronised sample, NSS wins and the byte is discarded.
  - A new NSS falling edge while in SKIP is impossible, because NSS must rise first.
- MISO: loads CORE_ID at frame start and shifts MSB first, updating on detected SCK falling edges. After byte 0 it drives 0. In IDLE it drives 0.
- Reset asserted mid-frame: immediate return to the reset values above. The accumulated counts are lost.

Optional Feature:
- Macro: SPI_HID_WATCHDOG_EN.
- With the macro defined:
  - A 24-bit counter increments every cycle and reloads on FRAME_STB.
  - On reaching TIMEOUT_CYCLES-1, JOY0, JOY1 and MOUSE_BUTTONS clear to 0 (releases stuck inputs if the ARM stalls). MOUSE_DATA is preserved.
  - The counter saturates until the next FRAME_STB.
- Without the macro: there is no counter, and outputs hold indefinitely.

Decomposition:
- Package spi_hid_pkg holds:
  - command codes CMD_JOY0, CMD_JOY1, CMD_MOUSE;
  - payload lengths per command;
  - the FSM state encoding;
  - the joystick bit-index constants.
- Sub-module spi_hid_sync contains:
  - the 2-FF synchronisers for three signals;
  - SCK rise/fall detect;
  - NSS fall/high outputs.
- It is instantiated once.

Test Plan:
- Reset: assert RESET_n=0 mid-frame -> all outputs 0, and the next frame 01,2A decodes normally with JOY0=6'h2A and one FRAME_STB.
- Mouse accumulate: frames 04,01,05,FB then 04,00,FC,08 -> MOUSE_BUTTONS=3'b000, MOUSE_DATA=16'h0301; two FRAME_STB pulses.
- Wrap: xcount=8'hFF, send 04,00,01,00 -> MOUSE_DATA[7:0]=8'h00, ycount unchanged.
- Abort and unknown command:
  - NSS raised after 01 plus 4 bits -> JOY0 unchanged, no FRAME_STB.
  - Frame 7F,11,22 -> no change, no FRAME_STB.
- MISO: any frame -> first 8 MISO bits read 8'hA1, then 0s; trailing bytes after 02,3F ignored with JOY1=6'h3F.
- Watchdog (macro on, TIMEOUT_CYCLES=100): JOY1=6'h10, idle 100 cycles -> JOY1=0, MOUSE_DATA preserved. With the macro off, the same stimulus -> JOY1 stays 6'h10.
